// File: rtl/fm_buffer_pkg.sv
// Shared definitions for the feature-map capture buffer: FSM encoding,
// default frame geometry and the raster-to-linear address mapping.
package fm_buffer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_t;

  localparam int FM_X_DFLT = 8;
  localparam int FM_Y_DFLT = 8;
  localparam int FM_DEPTH  = FM_X_DFLT * FM_Y_DFLT;

  // Row-major linear address of pixel (x,y) in a frame fm_x pixels wide.
  function automatic int fm_lin_addr(input int x, input int y, input int fm_x);
    return y * fm_x + x;
  endfunction

endpackage

// File: rtl/fm_lane_ram.sv
// Simple dual-port RAM: one synchronous write port and one registered,
// enable-gated read port whose output holds when the port is idle.
module fm_lane_ram #(
  parameter int ADDR_W = 6,
  parameter int WIDTH  = 16
) (
  input  logic              i_clock,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]  i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [WIDTH-1:0]  o_rd_data
);

  logic [WIDTH-1:0] r_mem [2**ADDR_W];
  logic [WIDTH-1:0] r_rd_data;

  // NOTE: the array has no reset branch so it maps onto block RAM; only
  // control state is reset, never the storage itself.
  always_ff @(posedge i_clock) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/fm_capture_buffer.sv
// Captures one rectified feature-map frame (all kernel lanes packed per word),
// holds it for random-access reads, and re-arms on a release pulse.
module fm_capture_buffer
  import fm_buffer_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int NUM_KERNELS = 2,
  parameter int FM_X        = FM_X_DFLT,
  parameter int FM_Y        = FM_Y_DFLT,
  parameter int COORD_W     = 10,
  parameter int ADDR_W      = 6
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_pixel_rdy,
  input  logic [COORD_W-1:0]            i_fm_x_coord,
  input  logic [COORD_W-1:0]            i_fm_y_coord,
  input  logic [DATA_W*NUM_KERNELS-1:0] i_pixel_vector,
  input  logic                          i_rd_en,
  input  logic [ADDR_W-1:0]             i_rd_addr,
  input  logic                          i_release,
  output logic [DATA_W*NUM_KERNELS-1:0] o_rd_data,
  output logic                          o_rd_valid,
  output logic                          o_buffer_full,
  output logic [ADDR_W:0]               o_fill_count,
  output logic                          o_overrun
);

  localparam int          WORD_W  = DATA_W * NUM_KERNELS;
  localparam int unsigned L_DEPTH = FM_X * FM_Y;

  state_t            r_state;
  logic              r_buffer_full;
  logic [ADDR_W:0]   r_fill_count;
  logic              r_overrun;
  logic              r_rd_valid;
  logic              r_rd_zero;

  logic              w_in_range;
  logic              w_origin;
  logic              w_last;
  logic              w_wr_en;
  logic [ADDR_W-1:0] w_wr_addr;
  logic              w_rd_take;
  logic              w_rd_in_range;
  logic [WORD_W-1:0] w_ram_q;

  // Range checks use the full coordinate width so large coordinates never alias.
  assign w_in_range = (i_fm_x_coord < COORD_W'(FM_X)) && (i_fm_y_coord < COORD_W'(FM_Y));
  assign w_origin   = (i_fm_x_coord == '0) && (i_fm_y_coord == '0);
  assign w_last     = (i_fm_x_coord == COORD_W'(FM_X - 1)) &&
                      (i_fm_y_coord == COORD_W'(FM_Y - 1));

  assign w_wr_en   = i_pixel_rdy &&
                     (((r_state == IDLE) && w_origin) || ((r_state == FILL) && w_in_range));
  assign w_wr_addr = ADDR_W'(fm_lin_addr(32'(i_fm_x_coord), 32'(i_fm_y_coord), FM_X));

  assign w_rd_take     = i_rd_en && (r_state == FULL);
  assign w_rd_in_range = 32'(i_rd_addr) < L_DEPTH;

  fm_lane_ram #(
    .ADDR_W (ADDR_W),
    .WIDTH  (WORD_W)
  ) u_ram (
    .i_clock   (i_clock),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (i_pixel_vector),
    .i_rd_en   (w_rd_take && w_rd_in_range),
    .i_rd_addr (i_rd_addr),
    .o_rd_data (w_ram_q)
  );

  // NOTE: every register below is written with <= so all of them sample the
  // pre-edge values; blocking = here would create order-dependent races.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= IDLE;
      r_buffer_full <= 1'b0;
      r_fill_count  <= '0;
      r_overrun     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_pixel_rdy && w_origin) begin
            r_fill_count <= (ADDR_W+1)'(1);
            if (w_last) begin
              r_state       <= FULL;
              r_buffer_full <= 1'b1;
            end else begin
              r_state <= FILL;
            end
          end
        end
        FILL: begin
          if (i_pixel_rdy && w_in_range) begin
            // A fresh (0,0) re-aligns the frame instead of counting on.
            if (w_origin) begin
              r_fill_count <= (ADDR_W+1)'(1);
            end else begin
              r_fill_count <= r_fill_count + 1'b1;
            end
            if (w_last) begin
              r_state       <= FULL;
              r_buffer_full <= 1'b1;
            end
          end
        end
        FULL: begin
          if (i_pixel_rdy) begin
            r_overrun <= 1'b1;
          end
          if (i_release) begin
            r_state       <= IDLE;
            r_buffer_full <= 1'b0;
            r_fill_count  <= '0;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Out-of-range reads leave the RAM idle and force the data word to zero.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_rd_valid <= 1'b0;
      r_rd_zero  <= 1'b1;
    end else begin
      r_rd_valid <= w_rd_take;
      if (w_rd_take) begin
        r_rd_zero <= !w_rd_in_range;
      end
    end
  end

  assign o_rd_data     = r_rd_zero ? '0 : w_ram_q;
  assign o_rd_valid    = r_rd_valid;
  assign o_buffer_full = r_buffer_full;
  assign o_fill_count  = r_fill_count;
  assign o_overrun     = r_overrun;

endmodule

// File: tb/tb_fm_capture_buffer.sv
// Directed bench for fm_capture_buffer: raster fills, alignment, read corner
// cases, overrun, release/read overlap and asynchronous reset mid-fill.
module tb_fm_capture_buffer;

  localparam int DATA_W = 8;
  localparam int NK     = 2;
  localparam int FMX    = 8;
  localparam int FMY    = 8;
  localparam int CW     = 10;
  localparam int AW     = 7;   // one spare address bit so addr 64 is drivable
  localparam int WW     = DATA_W * NK;

  logic          clock = 1'b0;
  logic          reset;
  logic          pixel_rdy;
  logic [CW-1:0] x_coord;
  logic [CW-1:0] y_coord;
  logic [WW-1:0] pixel_vector;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          rel;
  logic [WW-1:0] rd_data;
  logic          rd_valid;
  logic          buffer_full;
  logic [AW:0]   fill_count;
  logic          overrun;

  int n_checks = 0;
  int n_fail   = 0;

  fm_capture_buffer #(
    .DATA_W      (DATA_W),
    .NUM_KERNELS (NK),
    .FM_X        (FMX),
    .FM_Y        (FMY),
    .COORD_W     (CW),
    .ADDR_W      (AW)
  ) dut (
    .i_clock        (clock),
    .i_reset        (reset),
    .i_pixel_rdy    (pixel_rdy),
    .i_fm_x_coord   (x_coord),
    .i_fm_y_coord   (y_coord),
    .i_pixel_vector (pixel_vector),
    .i_rd_en        (rd_en),
    .i_rd_addr      (rd_addr),
    .i_release      (rel),
    .o_rd_data      (rd_data),
    .o_rd_valid     (rd_valid),
    .o_buffer_full  (buffer_full),
    .o_fill_count   (fill_count),
    .o_overrun      (overrun)
  );

  always #5 clock = ~clock;

  typedef struct {
    string         name;
    logic          pix;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic [WW-1:0] pdata;
    logic          rd;
    logic [AW-1:0] addr;
    logic          rel;
    logic          e_valid;
    logic [WW-1:0] e_data;
    logic          e_full;
    int            e_fc;
    logic          e_ov;
  } vec_t;

  function automatic vec_t mk(input string name, input logic pix, input int x, input int y,
                              input logic [WW-1:0] pdata, input logic rd, input int addr,
                              input logic rl, input logic e_valid, input logic [WW-1:0] e_data,
                              input logic e_full, input int e_fc, input logic e_ov);
    vec_t v;
    v.name = name;  v.pix = pix;  v.x = CW'(x);  v.y = CW'(y);  v.pdata = pdata;
    v.rd = rd;  v.addr = AW'(addr);  v.rel = rl;
    v.e_valid = e_valid;  v.e_data = e_data;  v.e_full = e_full;  v.e_fc = e_fc;  v.e_ov = e_ov;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [WW-1:0] d,
                           input logic f, input int fc, input logic ov);
    check({tag, " rd_valid"},    32'(rd_valid),    32'(v));
    check({tag, " rd_data"},     32'(rd_data),     32'(d));
    check({tag, " buffer_full"}, 32'(buffer_full), 32'(f));
    check({tag, " fill_count"},  32'(fill_count),  32'(fc));
    check({tag, " overrun"},     32'(overrun),     32'(ov));
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    pixel_rdy = 1'b0;  x_coord = '0;  y_coord = '0;  pixel_vector = '0;
    rd_en = 1'b0;  rd_addr = '0;  rel = 1'b0;
  endtask

  // Lane 0 carries x+8y; lane 1 repeats it, or carries it XOR 0xA5 when alt is set.
  function automatic logic [WW-1:0] pix_val(input int idx, input bit alt);
    logic [7:0] v;
    v = idx[7:0];
    return alt ? {v ^ 8'hA5, v} : {v, v};
  endfunction

  task automatic send_pix(input int x, input int y, input logic [WW-1:0] d);
    pixel_rdy = 1'b1;  x_coord = CW'(x);  y_coord = CW'(y);  pixel_vector = d;
    tick();
    idle_inputs();
  endtask

  task automatic send_range(input int lo, input int hi, input bit alt);
    for (int i = lo; i <= hi; i++) begin
      send_pix(i % FMX, i / FMX, pix_val(i, alt));
    end
  endtask

  task automatic read_once(input int addr);
    rd_en = 1'b1;  rd_addr = AW'(addr);
    tick();
    idle_inputs();
  endtask

  vec_t vecs[13];

  initial begin
    vecs[0]  = mk("rd19",        0, 0, 0, 16'h0000, 1, 19, 0, 1, 16'h1313, 1, 64, 0);
    vecs[1]  = mk("hold",        0, 0, 0, 16'h0000, 0,  0, 0, 0, 16'h1313, 1, 64, 0);
    vecs[2]  = mk("rd64_oor",    0, 0, 0, 16'h0000, 1, 64, 0, 1, 16'h0000, 1, 64, 0);
    vecs[3]  = mk("burst0",      0, 0, 0, 16'h0000, 1,  0, 0, 1, 16'h0000, 1, 64, 0);
    vecs[4]  = mk("burst1",      0, 0, 0, 16'h0000, 1,  1, 0, 1, 16'h0101, 1, 64, 0);
    vecs[5]  = mk("burst2",      0, 0, 0, 16'h0000, 1,  2, 0, 1, 16'h0202, 1, 64, 0);
    vecs[6]  = mk("burst3",      0, 0, 0, 16'h0000, 1,  3, 0, 1, 16'h0303, 1, 64, 0);
    vecs[7]  = mk("overrun_pix", 1, 0, 0, 16'hFFFF, 0,  0, 0, 0, 16'h0303, 1, 64, 1);
    vecs[8]  = mk("rd0_after_ov",0, 0, 0, 16'h0000, 1,  0, 0, 1, 16'h0000, 1, 64, 1);
    vecs[9]  = mk("rel_and_rd63",0, 0, 0, 16'h0000, 1, 63, 1, 1, 16'h3F3F, 0,  0, 1);
    vecs[10] = mk("rd_in_idle",  0, 0, 0, 16'h0000, 1,  5, 0, 0, 16'h3F3F, 0,  0, 1);
    vecs[11] = mk("rel_in_idle", 1, 5, 5, 16'h5555, 0,  0, 1, 0, 16'h3F3F, 0,  0, 1);
    vecs[12] = mk("idle_origin", 1, 0, 0, 16'h1111, 0,  0, 0, 0, 16'h3F3F, 0,  1, 1);

    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    check_out("reset", 0, 16'h0000, 0, 0, 0);
    reset = 1'b0;
    tick();

    // Pixels before frame alignment are discarded.
    send_pix(3, 2, 16'hDEAD);
    send_pix(4, 2, 16'hBEEF);
    check("align fill_count", 32'(fill_count), 32'd0);
    read_once(3);
    check("rd in IDLE rd_valid", 32'(rd_valid), 32'd0);

    send_range(0, 19, 1'b0);
    check("partial fill_count", 32'(fill_count), 32'd20);
    read_once(0);
    check_out("rd in FILL", 0, 16'h0000, 0, 20, 0);

    send_range(20, 62, 1'b0);
    check_out("before last", 0, 16'h0000, 0, 63, 0);
    send_range(63, 63, 1'b0);
    check_out("frame1 full", 0, 16'h0000, 1, 64, 0);

    for (int i = 0; i < 13; i++) begin
      pixel_rdy = vecs[i].pix;  x_coord = vecs[i].x;  y_coord = vecs[i].y;
      pixel_vector = vecs[i].pdata;  rd_en = vecs[i].rd;  rd_addr = vecs[i].addr;
      rel = vecs[i].rel;
      tick();
      idle_inputs();
      check_out(vecs[i].name, vecs[i].e_valid, vecs[i].e_data, vecs[i].e_full,
                vecs[i].e_fc, vecs[i].e_ov);
    end

    // Frame in progress from the last vector; abandon it with an async reset.
    send_range(1, 29, 1'b1);
    check("pre-reset fill_count", 32'(fill_count), 32'd30);
    reset = 1'b1;
    #1;
    check_out("async reset", 0, 16'h0000, 0, 0, 0);
    tick();
    reset = 1'b0;
    tick();

    send_range(0, 2, 1'b1);
    check("restart pre fill_count", 32'(fill_count), 32'd3);
    send_range(0, 0, 1'b1);
    check("restart fill_count", 32'(fill_count), 32'd1);
    send_pix(9, 0, 16'hAAAA);
    send_pix(10'h203, 0, 16'hBBBB);
    send_pix(2, 10'h105, 16'hCCCC);
    check("oor pixels fill_count", 32'(fill_count), 32'd1);
    send_range(1, 62, 1'b1);
    check("frame2 buffer_full early", 32'(buffer_full), 32'd0);
    send_range(63, 63, 1'b1);
    check_out("frame2 full", 0, 16'h0000, 1, 64, 0);
    read_once(63);
    check_out("frame2 rd63", 1, 16'h9A3F, 1, 64, 0);
    read_once(9);
    check_out("frame2 rd9", 1, 16'hAC09, 1, 64, 0);

    // Origin pixel landing with release: dropped, flagged, state still releases.
    pixel_rdy = 1'b1;  x_coord = '0;  y_coord = '0;  pixel_vector = 16'hFFFF;  rel = 1'b1;
    tick();
    idle_inputs();
    check_out("origin+release", 0, 16'hAC09, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fm_capture_buffer.md
Name: fm_capture_buffer

Overview:
- Sits directly downstream of the rect_linear lanes and fm_coord_sr.
- Captures one complete rectified feature-map frame for all kernels into on-chip RAM. Each write is addressed by the delayed (x,y) coordinates.
- When the frame is complete, it raises buffer_full and holds the frame stable.
- The fully-connected / matrix-multiply controller reads the frame through a registered random-access read port, then hands it back with a release pulse.

Parameters:
- DATA_W, 8, width of one rectified pixel per kernel lane.
- NUM_KERNELS, 2, number of kernel lanes packed side by side in one RAM word.
- FM_X, 8, feature-map width in pixels.
- FM_Y, 8, feature-map height in pixels.
- COORD_W, 10, width of the fm_x_coord and fm_y_coord inputs.
- ADDR_W, 6, read/write address width; must satisfy 2^ADDR_W >= FM_X*FM_Y.

Ports:
- clock  in  1  single design clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- pixel_rdy  in  1  pixel_vector and coordinates are valid this cycle.
- fm_x_coord  in  COORD_W  column of the current pixel.
- fm_y_coord  in  COORD_W  row of the current pixel.
- pixel_vector  in  DATA_W*NUM_KERNELS  lane k occupies bits [DATA_W*k +: DATA_W].
- rd_en  in  1  read request from the consumer.
- rd_addr  in  ADDR_W  linear read address, y*FM_X+x.
- release  in  1  single-cycle pulse: consumer is finished with the frame.
- rd_data  out  DATA_W*NUM_KERNELS  registered read data.
- rd_valid  out  1  rd_data is valid this cycle.
- buffer_full  out  1  a complete frame is held and readable.
- fill_count  out  ADDR_W+1  number of pixels written in the current frame.
- overrun  out  1  sticky flag: a pixel arrived while the frame was held.

Behaviour:
- Reset (asynchronous): state IDLE; buffer_full=0, rd_valid=0, rd_data=0, fill_count=0, overrun=0. RAM contents are not reset.
- States:
  - IDLE: waits for frame alignment. A pixel_rdy with x=0,y=0 is written to address 0, sets fill_count=1 and moves to FILL. Any other pixel is silently discarded.
  - FILL:
    - On pixel_rdy with x<FM_X and y<FM_Y: write pixel_vector to address y*FM_X+x and increment fill_count.
    - Out-of-range coordinates are discarded without counting.
    - The write at (FM_X-1, FM_Y-1) moves the state to FULL; buffer_full=1 from the next cycle.
    - A (0,0) pixel seen in FILL restarts the frame: write address 0, fill_count=1.
  - FULL: RAM write enable is forced to 0.
    - Every pixel_rdy sets overrun=1; the pixel is dropped.
    - release moves the state to IDLE and clears buffer_full and fill_count the next cycle.
- Reads:
  - rd_en is honoured only while the state is FULL.
  - rd_data and rd_valid update exactly one cycle after rd_en.
  - rd_en outside FULL gives rd_valid=0, and rd_data holds its previous value.
  - rd_addr >= FM_X*FM_Y gives rd_valid=1 with rd_data all-zero.
  - Back-to-back reads are supported at one read per cycle.
- Simultaneous events:
  - rd_en together with release in FULL: the read is serviced and the state still goes to IDLE.
  - pixel_rdy with (0,0) together with release: the pixel is dropped and overrun is set.
  - release outside FULL is ignored.
- Clearing overrun: only reset clears it.
- Arithmetic: the address product is computed at ADDR_W bits with no truncation for legal coordinates. The coordinate range comparisons use the full COORD_W bits.
- Reset mid-operation: any state returns to IDLE. The frame being captured is abandoned and the next frame must re-align on (0,0).

Decomposition:
- Package fm_buffer_pkg holds:
  - the state encoding (IDLE, FILL, FULL);
  - the localparam FM_DEPTH = FM_X*FM_Y;
  - the linear-address function (y*FM_X+x).
- One sub-module, fm_lane_ram: simple dual-port RAM with one write port and one registered read port, depth 2^ADDR_W, width DATA_W*NUM_KERNELS. It is instantiated once; the lanes are packed into one word.
- The FSM, counters, flags and read-valid pipeline live in the top of the block.

Test Plan:
- Full raster fill: write 64 pixels (0,0)..(7,7), each lane value = x+8y → buffer_full=1 one cycle after the (7,7) write; fill_count=64; reading addr 19 returns 19 in both lanes one cycle after rd_en.
- Alignment: send (3,2),(4,2) then the (0,0) raster → the first two pixels are ignored; fill_count=64 only after (7,7).
- Overrun: in FULL, pulse pixel_rdy at (0,0) with data 0xFF → overrun=1; addr 0 still reads 0; a later release returns to IDLE with overrun still 1.
- Read edge cases: rd_en in FILL → rd_valid=0; rd_addr=64 in FULL → rd_valid=1, rd_data=0; rd_en held 4 cycles on addr 0..3 → 4 consecutive valid beats.
- Same-cycle release and read: release with rd_en at addr 63 → rd_data = value at 63 and rd_valid=1 next cycle; buffer_full=0 that same cycle.
- Async reset mid-FILL at fill_count=30 → all outputs 0 immediately; a new raster then fills normally to 64.
